ysyx_24100005_mem_arbiter: RTL and testbench

YSYX_24100005_MEM_ARBITER -- requirements
Module: ysyx_24100005_mem_arbiter

---
 rtl/ysyx_24100005_mem_pkg.sv | 20 ++
 rtl/ysyx_24100005_rr_arb2.sv | 34 +++
 rtl/ysyx_24100005_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ysyx_24100005_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_mem_pkg.sv
// Shared types and default sizing for the IFU/LSU memory arbiter.
package ysyx_24100005_mem_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/ysyx_24100005_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 is the IFU, bit 1 is the LSU.
module ysyx_24100005_rr_arb2
    import ysyx_24100005_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    owner_e lastGrant_q, lastGrant_d;

    // On a conflict the requester that did not win last time gets the grant.
    always_comb begin
        gnt_o       = req_i;
        lastGrant_d = lastGrant_q;
        if (req_i == 2'b11) begin
            gnt_o = (lastGrant_q == OWN_LSU) ? 2'b01 : 2'b10;
        end
        if (advance_i && (gnt_o != 2'b00)) begin
            lastGrant_d = gnt_o[1] ? OWN_LSU : OWN_IFU;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lastGrant_q <= OWN_IFU;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// Shares one memory port between the IFU and LSU, one transaction in flight,
// with a bounded wait that turns a silent memory into an error response.
module ysyx_24100005_mem_arbiter
    import ysyx_24100005_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [CNT_W-1:0]  timeoutCnt_q;
    logic [1:0]        grant;
    logic              handshake;
    logic              timeoutHit;

    ysyx_24100005_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({lsu_req_valid, ifu_req_valid}),
        .advance_i (handshake),
        .gnt_o     (grant)
    );

    assign handshake  = (ifu_req_valid & ifu_req_ready) | (lsu_req_valid & lsu_req_ready);
    assign timeoutHit = (timeoutCnt_q >= CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (handshake)                     state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)                 state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid || timeoutHit)  state_d = ST_RESP;
            ST_RESP:                                    state_d = ST_IDLE;
            default:                                    state_d = ST_IDLE;
        endcase
    end

    // Instruction fetches carry no write payload, so their store fields are zeroed at latch time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q      <= OWN_IFU;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            timeoutCnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (handshake) begin
                        owner_q <= grant[1] ? OWN_LSU : OWN_IFU;
                        addr_q  <= grant[1] ? lsu_addr : ifu_addr;
                        wen_q   <= grant[1] & lsu_wen;
                        wdata_q <= grant[1] ? lsu_wdata : '0;
                        wmask_q <= grant[1] ? lsu_wmask : 8'h00;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        timeoutCnt_q <= '0;
                    end
                end
                ST_WAIT: begin
                    if (timeoutCnt_q != CNT_W'(TIMEOUT)) begin
                        timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
                    end
                    if (mem_resp_valid) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                    end else if (timeoutHit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Readys are gated by reset so every output is quiet while reset is held.
    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_addr       = '0;
        mem_wen        = 1'b0;
        mem_wdata      = '0;
        mem_wmask      = 8'h00;
        ifu_resp_valid = 1'b0;
        ifu_rdata      = '0;
        ifu_resp_err   = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_rdata      = '0;
        lsu_resp_err   = 1'b0;
        if (rst && (state_q == ST_IDLE)) begin
            ifu_req_ready = grant[0];
            lsu_req_ready = grant[1];
        end
        if (state_q == ST_REQ) begin
            mem_req_valid = 1'b1;
            mem_addr      = addr_q;
            mem_wen       = wen_q;
            mem_wdata     = wdata_q;
            mem_wmask     = wmask_q;
        end
        if (state_q == ST_RESP) begin
            if (owner_q == OWN_IFU) begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = rdata_q;
                ifu_resp_err   = err_q;
            end else begin
                lsu_resp_valid = 1'b1;
                lsu_rdata      = rdata_q;
                lsu_resp_err   = err_q;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
// Directed plus randomized transactions against a transaction-level model of
// arbitration order, response timing and timeout behaviour.
module tb_ysyx_24100005_mem_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int nCompared   = 0;
    int nMismatched = 0;
    bit lastWasLsu  = 1'b0;

    ysyx_24100005_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .ifu_resp_err   (ifu_resp_err),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .lsu_resp_err   (lsu_resp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_readys"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
        checkOutput({tag, "_memValid"}, mem_req_valid, 1'b0);
        checkOutput({tag, "_memFields"}, {mem_addr, mem_wen, mem_wmask}, '0);
        checkOutput({tag, "_resps"}, {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 4'b0);
    endtask

    // One complete transaction; the caller has already chosen the owner per the arbitration model.
    task automatic applyStimulus(input bit isLsu, input logic [31:0] addr, input bit wen,
                                 input logic [31:0] wdata, input logic [7:0] wmask,
                                 input int stall, input int lat, input logic [31:0] memData);
        logic [31:0] expWdata;
        logic [7:0]  expMask;
        logic [31:0] expRdata;
        bit          expWen, expErr, otherHeld;
        int          respAt;
        expWen   = isLsu & wen;
        expWdata = isLsu ? wdata : 32'h0;
        expMask  = isLsu ? wmask : 8'h00;
        expErr   = (lat >= TB_TIMEOUT);
        expRdata = expErr ? 32'h0 : memData;
        respAt   = expErr ? TB_TIMEOUT : lat + 1;
        if (isLsu) begin
            lsu_req_valid = 1'b1; lsu_addr = addr; lsu_wen = wen; lsu_wdata = wdata; lsu_wmask = wmask;
            otherHeld = ifu_req_valid;
        end else begin
            ifu_req_valid = 1'b1; ifu_addr = addr;
            otherHeld = lsu_req_valid;
        end
        #1;
        checkOutput("grantOwner", isLsu ? lsu_req_ready : ifu_req_ready, 1'b1);
        checkOutput("grantOther", isLsu ? ifu_req_ready : lsu_req_ready, 1'b0);
        lastWasLsu = isLsu;
        @(negedge clk);
        if (isLsu) begin
            lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
        end else begin
            ifu_req_valid = 1'b0; ifu_addr = $urandom;
        end
        for (int s = 0; s <= stall; s++) begin
            checkOutput("memReqValid", mem_req_valid, 1'b1);
            checkOutput("memAddr", mem_addr, addr);
            checkOutput("memWen", mem_wen, expWen);
            checkOutput("memWdata", mem_wdata, expWdata);
            checkOutput("memWmask", mem_wmask, expMask);
            checkOutput("readysBusy", {ifu_req_ready, lsu_req_ready}, 2'b00);
            mem_req_ready = (s == stall);
            @(negedge clk);
        end
        mem_req_ready = 1'b0;
        for (int k = 0; k <= respAt; k++) begin
            checkOutput("respOwner", isLsu ? lsu_resp_valid : ifu_resp_valid, k == respAt);
            checkOutput("respOther", isLsu ? ifu_resp_valid : lsu_resp_valid, 1'b0);
            checkOutput("readysWait", {ifu_req_ready, lsu_req_ready}, 2'b00);
            if (k == 0) begin
                checkOutput("memIdleFields", {mem_req_valid, mem_addr, mem_wdata}, '0);
            end
            if (k == respAt) begin
                checkOutput("respData", isLsu ? lsu_rdata : ifu_rdata, expRdata);
                checkOutput("respErr", isLsu ? lsu_resp_err : ifu_resp_err, expErr);
            end
            mem_resp_valid = (k == lat);
            mem_rdata      = (k == lat) ? memData : $urandom;
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        checkOutput("respAfter", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        checkOutput("otherReadyIdle", isLsu ? ifu_req_ready : lsu_req_ready, otherHeld);
    endtask

    initial begin
        bit          winLsu;
        int          pattern;
        logic [31:0] aIfu, aLsu, wd, md;
        logic [7:0]  wm;
        bit          we;

        rst = 1'b1;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
        #1 rst = 1'b0;
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        @(negedge clk); @(negedge clk);
        checkQuiet("inReset");
        rst = 1'b1;
        lastWasLsu = 1'b0;

        // Simultaneous requests right after reset: LSU first, then IFU, then LSU again.
        applyStimulus(1'b1, 32'h8000_0200, 1'b0, 32'h0, 8'h00, 0, 0, 32'h1111_2222);
        applyStimulus(1'b0, 32'h8000_0040, 1'b0, 32'h0, 8'h00, 0, 1, 32'h3333_4444);
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0044;
        applyStimulus(!lastWasLsu, 32'h8000_0204, 1'b1, 32'h5555_6666, 8'hF0, 1, 0, 32'h0);
        applyStimulus(1'b0, 32'h8000_0044, 1'b0, 32'h0, 8'h00, 0, 0, 32'h7777_8888);

        applyStimulus(1'b0, 32'h8000_0000, 1'b0, 32'h0, 8'h00, 0, 0, 32'h0000_0413);
        applyStimulus(1'b1, 32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 8'h0F, 3, 0, 32'hCAFE_0000);
        applyStimulus(1'b1, 32'h8000_0300, 1'b0, 32'h0, 8'h00, 0, 99, 32'hBAD0_BAD0);
        applyStimulus(1'b0, 32'h8000_0010, 1'b0, 32'h0, 8'h00, 2, TB_TIMEOUT - 1, 32'h1234_5678);

        mem_resp_valid = 1'b1; mem_rdata = 32'hFEED_F00D;
        @(negedge clk);
        checkQuiet("spurious1");
        @(negedge clk);
        mem_resp_valid = 1'b0;
        checkQuiet("spurious2");
        applyStimulus(1'b0, 32'h8000_0020, 1'b0, 32'h0, 8'h00, 0, 0, 32'h0000_0013);

        // Reset pulled in the middle of WAIT aborts the transaction silently.
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0500;
        #1 checkOutput("abortGrant", ifu_req_ready, 1'b1);
        @(negedge clk);
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1 checkQuiet("abortReset");
        mem_resp_valid = 1'b1; mem_rdata = 32'hABCD_EF01;
        @(negedge clk);
        rst = 1'b1;
        lastWasLsu = 1'b0;
        #1 checkQuiet("abortRelease");
        @(negedge clk);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkQuiet("abortAfter");
            @(negedge clk);
        end
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0600;
        applyStimulus(1'b1, 32'h8000_0700, 1'b0, 32'h0, 8'h00, 0, 0, 32'h0BAD_CAFE);
        applyStimulus(1'b0, 32'h8000_0600, 1'b0, 32'h0, 8'h00, 0, 0, 32'h00C0_FFEE);

        for (int t = 0; t < 24; t++) begin
            pattern = $urandom_range(1, 3);
            aIfu = $urandom; aLsu = $urandom; wd = $urandom; md = $urandom;
            wm = 8'($urandom); we = 1'($urandom);
            if (pattern == 3) begin
                winLsu = !lastWasLsu;
                if (winLsu) begin
                    ifu_req_valid = 1'b1; ifu_addr = aIfu;
                    applyStimulus(1'b1, aLsu, we, wd, wm, $urandom_range(0, 3), $urandom_range(0, 5), md);
                    applyStimulus(1'b0, aIfu, 1'b0, 32'h0, 8'h00, $urandom_range(0, 3), $urandom_range(0, 5), ~md);
                end else begin
                    lsu_req_valid = 1'b1; lsu_addr = aLsu; lsu_wen = we; lsu_wdata = wd; lsu_wmask = wm;
                    applyStimulus(1'b0, aIfu, 1'b0, 32'h0, 8'h00, $urandom_range(0, 3), $urandom_range(0, 5), ~md);
                    applyStimulus(1'b1, aLsu, we, wd, wm, $urandom_range(0, 3), $urandom_range(0, 5), md);
                end
            end else begin
                applyStimulus(pattern == 2, (pattern == 2) ? aLsu : aIfu, we, wd, wm,
                              $urandom_range(0, 3), $urandom_range(0, 5), md);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
